// File: rtl/e203_dtcm_arbt_sched.sv
// e203_dtcm_arbt_sched
//   Shares one DTCM ICB port between the LSU and an external agent.
//   The LSU has fixed priority. A starvation counter forces an ext grant
//   after STARVE_MAX consecutive lost cycles. Responses are routed in order
//   to their originator through a small requester-ID FIFO.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   lsu_icb_cmd_*         LSU command (valid/ready/addr/read/wdata/wmask)
//   lsu_icb_rsp_*         LSU response (valid/ready/err/rdata)
//   ext_icb_cmd_*         external-agent command, same fields as the LSU
//   ext_icb_rsp_*         external-agent response, same fields as the LSU
//   o_icb_cmd_*           muxed command towards the SRAM controller
//   o_icb_rsp_*           response coming back from the SRAM controller
//   starve_boost          ext currently holds forced priority
//   arbt_active           any command pending or any transaction outstanding
module e203_dtcm_arbt_sched #(
  parameter int AW         = 16,
  parameter int DW         = 32,
  parameter int MW         = 4,
  parameter int OUTS_NUM   = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          lsu_icb_cmd_valid,
  output logic          lsu_icb_cmd_ready,
  input  logic [AW-1:0] lsu_icb_cmd_addr,
  input  logic          lsu_icb_cmd_read,
  input  logic [DW-1:0] lsu_icb_cmd_wdata,
  input  logic [MW-1:0] lsu_icb_cmd_wmask,
  output logic          lsu_icb_rsp_valid,
  input  logic          lsu_icb_rsp_ready,
  output logic          lsu_icb_rsp_err,
  output logic [DW-1:0] lsu_icb_rsp_rdata,

  input  logic          ext_icb_cmd_valid,
  output logic          ext_icb_cmd_ready,
  input  logic [AW-1:0] ext_icb_cmd_addr,
  input  logic          ext_icb_cmd_read,
  input  logic [DW-1:0] ext_icb_cmd_wdata,
  input  logic [MW-1:0] ext_icb_cmd_wmask,
  output logic          ext_icb_rsp_valid,
  input  logic          ext_icb_rsp_ready,
  output logic          ext_icb_rsp_err,
  output logic [DW-1:0] ext_icb_rsp_rdata,

  output logic          o_icb_cmd_valid,
  input  logic          o_icb_cmd_ready,
  output logic [AW-1:0] o_icb_cmd_addr,
  output logic          o_icb_cmd_read,
  output logic [DW-1:0] o_icb_cmd_wdata,
  output logic [MW-1:0] o_icb_cmd_wmask,
  input  logic          o_icb_rsp_valid,
  output logic          o_icb_rsp_ready,
  input  logic          o_icb_rsp_err,
  input  logic [DW-1:0] o_icb_rsp_rdata,

  output logic          starve_boost,
  output logic          arbt_active
);

  localparam int SCW = $clog2(STARVE_MAX + 1);
  localparam int PW  = (OUTS_NUM > 1) ? $clog2(OUTS_NUM) : 1;
  localparam int CW  = $clog2(OUTS_NUM + 1);

  // ID FIFO: 0 = LSU, 1 = ext
  logic          r_fifo [OUTS_NUM];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic [SCW-1:0] r_sc;

  logic w_full;
  logic w_empty;
  logic w_head;
  logic w_gnt_ext;
  logic w_gnt_lsu;
  logic w_push;
  logic w_pop;
  logic w_ext_hs;

  assign w_full  = (r_cnt == CW'(OUTS_NUM));
  assign w_empty = (r_cnt == '0);
  assign w_head  = r_fifo[r_rptr];

  assign starve_boost = (r_sc == SCW'(STARVE_MAX));

  // Grant
  assign w_gnt_ext = ext_icb_cmd_valid & (starve_boost | ~lsu_icb_cmd_valid);
  assign w_gnt_lsu = lsu_icb_cmd_valid & ~w_gnt_ext;

  // Full blocks issue even when a pop happens this cycle, so the command
  // ready path never depends on the response handshake.
  assign o_icb_cmd_valid   = (lsu_icb_cmd_valid | ext_icb_cmd_valid) & ~w_full;
  assign o_icb_cmd_addr    = w_gnt_ext ? ext_icb_cmd_addr  : lsu_icb_cmd_addr;
  assign o_icb_cmd_read    = w_gnt_ext ? ext_icb_cmd_read  : lsu_icb_cmd_read;
  assign o_icb_cmd_wdata   = w_gnt_ext ? ext_icb_cmd_wdata : lsu_icb_cmd_wdata;
  assign o_icb_cmd_wmask   = w_gnt_ext ? ext_icb_cmd_wmask : lsu_icb_cmd_wmask;

  assign lsu_icb_cmd_ready = w_gnt_lsu & o_icb_cmd_ready & ~w_full;
  assign ext_icb_cmd_ready = w_gnt_ext & o_icb_cmd_ready & ~w_full;

  assign w_push   = o_icb_cmd_valid & o_icb_cmd_ready;
  assign w_ext_hs = w_push & w_gnt_ext;

  // Response routing by FIFO head; payload fans out to both ports.
  assign lsu_icb_rsp_valid = o_icb_rsp_valid & ~w_empty & ~w_head;
  assign ext_icb_rsp_valid = o_icb_rsp_valid & ~w_empty &  w_head;
  assign o_icb_rsp_ready   = ~w_empty & (w_head ? ext_icb_rsp_ready : lsu_icb_rsp_ready);
  assign lsu_icb_rsp_err   = o_icb_rsp_err;
  assign ext_icb_rsp_err   = o_icb_rsp_err;
  assign lsu_icb_rsp_rdata = o_icb_rsp_rdata;
  assign ext_icb_rsp_rdata = o_icb_rsp_rdata;

  assign w_pop = o_icb_rsp_valid & o_icb_rsp_ready;

  assign arbt_active = lsu_icb_cmd_valid | ext_icb_cmd_valid | ~w_empty;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUTS_NUM - 1)) ? '0 : p + PW'(1);
  endfunction

  // ID storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wptr] <= w_gnt_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Starvation counter: counts ext cycles without a handshake, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sc <= '0;
    end else if (w_ext_hs) begin
      r_sc <= '0;
    end else if (ext_icb_cmd_valid && !starve_boost) begin
      r_sc <= r_sc + SCW'(1);
    end
  end

endmodule
